// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for a 5-stage pipeline. It resolves three conditions in
// priority order: memory stall > taken-branch flush > load-use stall.
// The stall and flush outputs are combinational from the FSM state and the
// inputs. A 2-state FSM (RUN / MEM_WAIT) tracks outstanding data-memory
// accesses, and an 8-bit wait counter raises a sticky timeout flag.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the three 16-bit
// saturating performance counters. Without it the count outputs are tied to
// 0 and clr_cnt is ignored.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   id_src1/2         source register indices of the instruction in ID
//   id_use_src1/2     the ID instruction actually reads the source
//   exe_dest          destination index held in ID/EX
//   exe_wb_en         ID/EX write-back enable
//   exe_mem_r_en      ID/EX memory read enable
//   exe_b             branch taken, resolved in EXE
//   mem_req           MEM-stage access pending
//   mem_ready         data memory ready
//   clr_cnt           synchronous clear of the performance counters
//   pc_stall, ifid_stall, idex_stall, exmem_stall   hold PC / pipeline regs
//   ifid_flush, idex_flush                          bubble insertion
//   mem_timeout       sticky memory-wait timeout (registered)
//   stall_cnt, flush_cnt, lu_cnt                    performance counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_use_src1,
    input  logic        id_use_src2,
    input  logic [3:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic        exe_b,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        clr_cnt,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        exmem_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] lu_cnt
);

    localparam int unsigned WAIT_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_timeout;

    logic w_mem_stall;
    logic w_load_use;
    logic w_br_flush;
    logic w_lu_stall;

    // Hazard detection and priority resolution
    assign w_mem_stall = ((r_state == RUN) && mem_req && !mem_ready) ||
                         ((r_state == MEM_WAIT) && !mem_ready);
    assign w_load_use  = exe_mem_r_en && exe_wb_en &&
                         ((id_use_src1 && (id_src1 == exe_dest)) ||
                          (id_use_src2 && (id_src2 == exe_dest)));
    assign w_br_flush  = !w_mem_stall && exe_b;
    assign w_lu_stall  = !w_mem_stall && !exe_b && w_load_use;

    // A load-use stall holds PC and IF/ID and injects a bubble into ID/EX
    assign pc_stall    = w_mem_stall | w_lu_stall;
    assign ifid_stall  = w_mem_stall | w_lu_stall;
    assign idex_stall  = w_mem_stall;
    assign exmem_stall = w_mem_stall;
    assign ifid_flush  = w_br_flush;
    assign idex_flush  = w_br_flush | w_lu_stall;

    assign mem_timeout = r_mem_timeout;

    // Memory-wait FSM, wait counter and sticky timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        if (r_wait_cnt == {WAIT_W{1'b1}}) begin
                            r_mem_timeout <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_lu_cnt;

    // Saturating event counters; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_lu_cnt    <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_lu_cnt    <= '0;
        end else begin
            if (w_mem_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_br_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (w_lu_stall && (r_lu_cnt != {CNT_W{1'b1}})) begin
                r_lu_cnt <= r_lu_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign lu_cnt    = r_lu_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_cnt;

    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign lu_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model of the hazard rules (priority, wait/timeout, counters).
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_src1, id_src2, exe_dest;
    logic        id_use_src1, id_use_src2;
    logic        exe_wb_en, exe_mem_r_en, exe_b;
    logic        mem_req, mem_ready, clr_cnt;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt, lu_cnt;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_b(exe_b), .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .lu_cnt(lu_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_wait;
    int m_wcnt;
    bit m_to;
    int m_stall, m_flush, m_lu;
    bit e_ms, e_br, e_lus;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_to = 0;
        m_stall = 0; m_flush = 0; m_lu = 0;
    endtask

    // Expected stall/flush pattern from the priority rules
    task automatic check_comb(input string tag);
        bit lu;
        logic [5:0] obs, exp;
        #1;
        e_ms  = m_wait ? !mem_ready : (mem_req && !mem_ready);
        lu    = exe_mem_r_en && exe_wb_en &&
                ((id_use_src1 && id_src1 == exe_dest) || (id_use_src2 && id_src2 == exe_dest));
        e_br  = !e_ms && exe_b;
        e_lus = !e_ms && !exe_b && lu;
        obs = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};
        if (e_ms)       exp = 6'b111100;
        else if (e_br)  exp = 6'b000011;
        else if (e_lus) exp = 6'b110001;
        else            exp = 6'b000000;
        chk({tag, "_ctl"}, 16'(obs), 16'(exp));
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_timeout"}, 16'(mem_timeout), 16'(m_to));
        chk({tag, "_stall_cnt"}, stall_cnt, 16'(m_stall));
        chk({tag, "_flush_cnt"}, flush_cnt, 16'(m_flush));
        chk({tag, "_lu_cnt"}, lu_cnt, 16'(m_lu));
    endtask

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Advance the model across one rising edge using the held inputs
    task automatic model_edge();
        if (PERF) begin
            if (clr_cnt) begin
                m_stall = 0; m_flush = 0; m_lu = 0;
            end else begin
                if (e_ms)  m_stall = sat16(m_stall);
                if (e_br)  m_flush = sat16(m_flush);
                if (e_lus) m_lu    = sat16(m_lu);
            end
        end
        if (m_wait) begin
            if (mem_ready) begin
                m_wait = 0; m_wcnt = 0;
            end else begin
                if (m_wcnt == 255) m_to = 1;
                if (m_wcnt < 255) m_wcnt++;
            end
        end else if (mem_req && !mem_ready) begin
            m_wait = 1;
        end
    endtask

    task automatic cycle(input string tag);
        check_comb(tag);
        @(posedge clk);
        model_edge();
        #1;
        check_regs(tag);
    endtask

    task automatic idle_inputs();
        id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_use_src2 = 0;
        exe_dest = 4'd15; exe_wb_en = 0; exe_mem_r_en = 0; exe_b = 0;
        mem_req = 0; mem_ready = 0; clr_cnt = 0;
    endtask

    task automatic load_use_inputs();
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3;
        id_use_src2 = 1; id_src2 = 4'd3; id_use_src1 = 0; id_src1 = 4'd0;
        exe_b = 0; mem_req = 0; mem_ready = 0;
    endtask

    initial begin
        int s0;
        idle_inputs();
        rst = 1'b1;
        model_reset();

        // Reset state
        #12;
        check_comb("reset");
        check_regs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Load-use stall, three consecutive cycles
        load_use_inputs();
        for (int i = 0; i < 3; i++) cycle("loaduse");
        chk("loaduse_lu_cnt_total", lu_cnt, PERF ? 16'd3 : 16'd0);

        // Branch overrides load-use
        exe_b = 1;
        for (int i = 0; i < 2; i++) cycle("branch_over_lu");
        chk("branch_lu_cnt_held", lu_cnt, PERF ? 16'd3 : 16'd0);
        chk("branch_flush_cnt", flush_cnt, PERF ? 16'd2 : 16'd0);

        // Memory stall for 4 cycles with branch and load-use deferred
        s0 = m_stall;
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) cycle("memstall");
        mem_ready = 1;
        cycle("mem_ready");
        chk("mem_ready_pc_stall", 16'(pc_stall), 16'd0);
        chk("memstall_cnt", stall_cnt, PERF ? 16'(s0 + 4) : 16'd0);
        idle_inputs();
        cycle("back_to_run");
        chk("run_no_stall", 16'(idex_stall), 16'd0);

        // Long wait: timeout at the 256th edge after entry, sticky afterwards
        mem_req = 1; mem_ready = 0;
        cycle("to_entry");
        for (int j = 1; j <= 300; j++) begin
            cycle("to_wait");
            if (j == 255) chk("timeout_before_256", 16'(mem_timeout), 16'd0);
            if (j == 256) chk("timeout_at_256", 16'(mem_timeout), 16'd1);
        end
        mem_ready = 1;
        cycle("to_ready");
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("to_sticky");
        chk("timeout_sticky", 16'(mem_timeout), 16'd1);

        // Asynchronous reset in the middle of MEM_WAIT
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) cycle("pre_rst_wait");
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        model_reset();
        check_comb("async_rst");
        check_regs("async_rst");
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        cycle("after_rst");

        // Counter clear wins over increment
        load_use_inputs();
        for (int i = 0; i < 4; i++) cycle("pre_clr");
        clr_cnt = 1;
        cycle("clr");
        chk("clr_lu_cnt", lu_cnt, 16'd0);
        clr_cnt = 0;
        cycle("post_clr");

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            exe_dest     = 4'($urandom_range(0, 3));
            id_use_src1  = 1'($urandom_range(0, 1));
            id_use_src2  = 1'($urandom_range(0, 1));
            exe_wb_en    = ($urandom_range(0, 3) != 0);
            exe_mem_r_en = ($urandom_range(0, 2) != 0);
            exe_b        = ($urandom_range(0, 4) == 0);
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ready    = ($urandom_range(0, 2) != 0);
            clr_cnt      = ($urandom_range(0, 99) == 0);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
